// File: rtl/cla_serial_pkg.sv
// rtl/cla_serial_pkg.sv - shared constants, state type and helpers for the nibble-serial CLA adder
package cla_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic int nib_count(input int width);
        return width / NIBBLE_W;
    endfunction

endpackage

// File: rtl/cla4_slice.sv
// rtl/cla4_slice.sv - combinational 4-bit carry-lookahead slice; CLA_SERIAL_OVF_EN exposes c3
module cla4_slice
    import cla_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                ci,
    output logic [NIBBLE_W-1:0] sum,
`ifdef CLA_SERIAL_OVF_EN
    output logic                c3,
`endif
    output logic                co
);

    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;

    assign g = x & y;
    assign p = x ^ y;

    // Every carry is flattened from ci, g and p so no carry waits on another.
    assign c[0] = ci;
    assign c[1] = g[0] | (p[0] & ci);
    assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & ci);

    assign sum = p ^ c[3:0];
    assign co  = c[4];
`ifdef CLA_SERIAL_OVF_EN
    assign c3  = c[3];
`endif

endmodule

// File: rtl/cla_nibble_serial_adder.sv
// rtl/cla_nibble_serial_adder.sv - WIDTH-bit adder reusing one CLA slice, one nibble per clock, LSB nibble first
// Optional signed-overflow output is enabled by defining CLA_SERIAL_OVF_EN.
module cla_nibble_serial_adder
    import cla_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef CLA_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int NIB   = nib_count(WIDTH);
    localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;

    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
        $error("cla_nibble_serial_adder: WIDTH must be a multiple of 4 and at least 4");
    end

    state_t             state;
    state_t             state_next;
    logic               accept;
    logic               last;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [WIDTH-1:0]   s_reg;
    logic [IDX_W-1:0]   idx;
    logic               carry;
    logic               cout_reg;
    logic               done_reg;
    logic [NIBBLE_W-1:0] x_nib;
    logic [NIBBLE_W-1:0] y_nib;
    logic [NIBBLE_W-1:0] sum_nib;
    logic               co_nib;
`ifdef CLA_SERIAL_OVF_EN
    logic               c3_nib;
    logic               ovf_reg;
`endif

    assign x_nib = a_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign y_nib = b_reg[NIBBLE_W*idx +: NIBBLE_W];
    assign last  = (idx == IDX_W'(NIB - 1));

    cla4_slice u_slice (
        .x   (x_nib),
        .y   (y_nib),
        .ci  (carry),
        .sum (sum_nib),
`ifdef CLA_SERIAL_OVF_EN
        .c3  (c3_nib),
`endif
        .co  (co_nib)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            s_reg    <= '0;
            idx      <= '0;
            carry    <= 1'b0;
            cout_reg <= 1'b0;
            done_reg <= 1'b0;
`ifdef CLA_SERIAL_OVF_EN
            ovf_reg  <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                a_reg <= a;
                b_reg <= b;
                carry <= cin;
                idx   <= '0;
                s_reg <= '0;
            end else if (state == RUN) begin
                s_reg[NIBBLE_W*idx +: NIBBLE_W] <= sum_nib;
                carry <= co_nib;
                if (last) begin
                    idx      <= '0;
                    cout_reg <= co_nib;
                    done_reg <= 1'b1;
`ifdef CLA_SERIAL_OVF_EN
                    // Carry into the MSB differing from carry out of it is signed overflow.
                    ovf_reg  <= c3_nib ^ co_nib;
`endif
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = done_reg;
    assign s    = s_reg;
    assign cout = cout_reg;
`ifdef CLA_SERIAL_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: doc/cla_nibble_serial_adder.md
Name: cla_nibble_serial_adder

Overview:
- Multi-cycle wide adder that streams WIDTH-bit operands through one 4-bit carry-lookahead slice, one nibble per clock, least significant nibble first.
- The carry between nibbles is held in a register.
- Sits directly upstream of, and wraps, the 4-bit CLA datapath. It supplies sequenced nibble operands and carry-in, and collects the sum nibbles and carry-out.
- Lets the team reuse the verified 4-bit slice for 16/32-bit sums without replicating the slice.

Parameters:
- WIDTH, 16, operand/result width in bits. Must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIB, WIDTH/4, derived localparam: number of nibble iterations.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in to nibble 0; latched when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse: result valid.
- s  output  WIDTH  sum; held stable from done until the next accepted start.
- cout  output  1  carry out of the MSB nibble; held like s.

Behaviour:
- Reset (rst_n low at a clk edge): state=IDLE; busy=0; done=0; s=0; cout=0; nibble index=0; carry register=0; operand registers=0. Reset overrides every other event, including mid-RUN; a partial result is discarded and no done is issued.
- IDLE:
  - start=1 at an edge latches a, b, cin into operand registers.
  - Carry register is loaded with cin, index=0, s cleared to 0, state goes to RUN.
  - start=0: state unchanged.
- RUN, one nibble per edge:
  - Slice inputs are a_reg[4i+3:4i], b_reg[4i+3:4i] and the carry register.
  - s[4i+3:4i] takes the slice sum; the carry register takes the slice carry-out; index increments.
  - At the edge where index==NIB-1: cout is loaded with the final carry-out, index is reset to 0, state goes to IDLE, and done is set to 1.
- done is registered and high for exactly one cycle, in the first IDLE cycle.
- Latency: start accepted at edge 0, done high in the cycle after edge NIB (NIB cycles; 4 for WIDTH=16).
- start while busy is ignored and not queued. Operand input changes during RUN have no effect.
- start high in the same cycle as done is accepted (state is IDLE), so back-to-back throughput is one result per NIB+1 cycles.
- busy is combinational from state (state==RUN).
- Arithmetic: unsigned modulo 2^WIDTH; {cout,s} equals a+b+cin exactly.
- No X propagation: every register has a defined reset value.

Optional Feature:
- Macro CLA_SERIAL_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit, reset 0), registered alongside cout at the final nibble edge.
  - ovf = carry into the MSB of the final nibble XOR cout, i.e. two's-complement signed overflow.
  - The slice exposes its internal bit-2 carry for this.
  - ovf is held like s.
- When undefined: no ovf port, no extra logic; behaviour otherwise identical.

Decomposition:
- Package cla_serial_pkg contains:
  - NIBBLE_W=4.
  - State enum type (IDLE, RUN), 1-bit encoding.
  - Function nib_count(width) returning width/NIBBLE_W.
- One natural sub-module: cla4_slice. It is a pure combinational 4-bit carry-lookahead with:
  - inputs: x[3:0], y[3:0], ci.
  - outputs: sum[3:0], co, c3 (internal carry into bit 3).
- The top contains the FSM, index counter, operand, carry and result registers, and the nibble mux/demux.

Test Plan:
- WIDTH=16, reset for 2 cycles, then a=16'h1234, b=16'h4321, cin=0, start pulse: expect busy high for 4 cycles, done exactly 4 cycles after the start edge, s=16'h5555, cout=0.
- a=16'hFFFF, b=16'h0001, cin=0: expect carry rippling through all nibbles, s=16'h0000, cout=1. Also a=16'hFFFF, b=16'h0000, cin=1: expect same result.
- Start a=16'h00F0, b=16'h0010; re-assert start with different operands on each RUN cycle: expect ignored, s=16'h0100, single done pulse.
- Assert rst_n=0 at the 2nd RUN cycle of any sum: expect next cycle busy=0, done=0, s=0, cout=0, and no done afterwards until a new start.
- Hold start high continuously with a=16'hABCD, b=16'h1111, cin=1: expect results s=16'hBCDF, cout=0 every 5 cycles.
- Exhaustive WIDTH=4 sweep of all a, b, cin combinations against a+b+cin. With CLA_SERIAL_OVF_EN, WIDTH=16: a=16'h7FFF, b=16'h0001 gives ovf=1; a=16'hFFFF, b=16'h0001 gives ovf=0.
